fp_div: RTL and testbench



---
 rtl/fp_pkg.sv | 61 ++++++
 rtl/fp_div_stage.sv | 47 ++++
 rtl/fp_div.sv | 147 ++++++++++++++
 tb/tb_fp_div.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared single-precision float definitions: field widths, special encodings,
// the unpacked operand record and the record carried down the divider pipeline.
// No ports; imported by fp_div and fp_div_stage.
package fp_pkg;

  localparam int FP_W        = 32;
  localparam int FP_EXP_W    = 8;
  localparam int FP_FRAC_W   = 23;
  localparam int FP_SIG_W    = FP_FRAC_W + 1;   // hidden bit restored
  localparam int FP_EXP_BIAS = 127;

  localparam logic [FP_W-1:0] FP_QNAN    = 32'h7FC00000;
  localparam logic [FP_W-1:0] FP_POS_INF = 32'h7F800000;

  // Divider internals: signed working exponent, quotient (1 int + 23 frac +
  // guard + round) and a partial remainder one bit wider than the divisor.
  localparam int FP_EXPI_W = 10;
  localparam int FP_Q_W    = 26;
  localparam int FP_REM_W  = FP_SIG_W + 1;

  typedef struct packed {
    logic                sign;
    logic [FP_EXP_W-1:0] exp;
    logic [FP_SIG_W-1:0] sig;
    logic                is_zero;
    logic                is_inf;
    logic                is_nan;
  } fp_unpacked_t;

  // Encoding 0 is SPC_ZERO so that a cleared pipeline register flows out as
  // +0 rather than as an arithmetic underflow of an all-zero quotient.
  typedef enum logic [2:0] {
    SPC_ZERO = 3'd0,
    SPC_NONE = 3'd1,
    SPC_NAN  = 3'd2,
    SPC_INF  = 3'd3,
    SPC_DBZ  = 3'd4
  } fp_spc_t;

  typedef struct packed {
    logic                 sign;
    logic [FP_EXPI_W-1:0] exp;   // two's complement biased exponent
    fp_spc_t              spc;
    logic [FP_REM_W-1:0]  rem;
    logic [FP_Q_W-1:0]    q;
    logic [FP_SIG_W-1:0]  div;
  } fp_div_pipe_t;

  // Denormals (exponent 0) are treated as zero.
  function automatic fp_unpacked_t fp_unpack(input logic [FP_W-1:0] x);
    fp_unpacked_t u;
    u.sign    = x[FP_W-1];
    u.exp     = x[FP_W-2:FP_FRAC_W];
    u.is_zero = (x[FP_W-2:FP_FRAC_W] == '0);
    u.is_inf  = (x[FP_W-2:FP_FRAC_W] == '1) && (x[FP_FRAC_W-1:0] == '0);
    u.is_nan  = (x[FP_W-2:FP_FRAC_W] == '1) && (x[FP_FRAC_W-1:0] != '0);
    u.sig     = u.is_zero ? '0 : {1'b1, x[FP_FRAC_W-1:0]};
    return u;
  endfunction

endpackage

// File: rtl/fp_div_stage.sv
// One registered block of K restoring-division iterations.
// Ports: clock/reset/clk_en, pipe_in (remainder, quotient so far, divisor,
// exponent, sign, special class) and the registered pipe_out.
module fp_div_stage
  import fp_pkg::*;
#(
  parameter int K = 7
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         clk_en,
  input  fp_div_pipe_t pipe_in,
  output fp_div_pipe_t pipe_out
);

  fp_div_pipe_t        nxt;
  logic [FP_REM_W-1:0] rem;
  logic [FP_Q_W-1:0]   q;

  // Remainder stays below twice the divisor, so the shift after each
  // compare/subtract never loses a set bit.
  always_comb begin
    rem = pipe_in.rem;
    q   = pipe_in.q;
    for (int i = 0; i < K; i++) begin
      if (rem >= {1'b0, pipe_in.div}) begin
        rem = rem - {1'b0, pipe_in.div};
        q   = {q[FP_Q_W-2:0], 1'b1};
      end else begin
        q   = {q[FP_Q_W-2:0], 1'b0};
      end
      rem = {rem[FP_REM_W-2:0], 1'b0};
    end
    nxt     = pipe_in;
    nxt.rem = rem;
    nxt.q   = q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pipe_out <= '0;
    end else if (clk_en) begin
      pipe_out <= nxt;
    end
  end

endmodule

// File: rtl/fp_div.sv
// Pipelined IEEE-754 single-precision divider, result = dataa / datab, fixed
// latency of 6 enabled clocks, one operand pair per enabled clock.
// Ports: clock, reset (sync, active high), clk_en, dataa, datab, result.
// Optional macro FP_DIV_FLAGS_EN adds registered flags nan, division_by_zero,
// overflow, underflow and zero, aligned with result.
module fp_div
  import fp_pkg::*;
#(
  parameter int LATENCY = 6
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            clk_en,
  input  logic [FP_W-1:0] dataa,
  input  logic [FP_W-1:0] datab,
  output logic [FP_W-1:0] result
`ifdef FP_DIV_FLAGS_EN
  ,
  output logic            nan,
  output logic            division_by_zero,
  output logic            overflow,
  output logic            underflow,
  output logic            zero
`endif
);

  if (LATENCY != 6) begin : g_latency_unsupported
    $error("fp_div supports LATENCY = 6 only");
  end

  // ---------------- S0: unpack and classify ----------------
  fp_unpacked_t ua, ub;
  fp_div_pipe_t s0_nxt, s0, s1, s2, s3, s4;

  assign ua = fp_unpack(dataa);
  assign ub = fp_unpack(datab);

  always_comb begin
    s0_nxt      = '0;
    s0_nxt.sign = ua.sign ^ ub.sign;
    s0_nxt.exp  = {2'b00, ua.exp} - {2'b00, ub.exp} + FP_EXPI_W'(FP_EXP_BIAS);
    s0_nxt.rem  = {1'b0, ua.sig};
    s0_nxt.div  = ub.sig;
    if (ua.is_nan || ub.is_nan || (ua.is_zero && ub.is_zero) || (ua.is_inf && ub.is_inf)) begin
      s0_nxt.spc = SPC_NAN;
    end else if (ua.is_inf) begin
      s0_nxt.spc = SPC_INF;
    end else if (ub.is_zero) begin
      s0_nxt.spc = SPC_DBZ;
    end else if (ub.is_inf || ua.is_zero) begin
      s0_nxt.spc = SPC_ZERO;
    end else begin
      s0_nxt.spc = SPC_NONE;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      s0 <= '0;
    end else if (clk_en) begin
      s0 <= s0_nxt;
    end
  end

  // ---------------- S1..S4: 7 + 7 + 6 + 6 quotient bits ----------------
  fp_div_stage #(.K(7)) u_stage1 (.clock(clock), .reset(reset), .clk_en(clk_en), .pipe_in(s0), .pipe_out(s1));
  fp_div_stage #(.K(7)) u_stage2 (.clock(clock), .reset(reset), .clk_en(clk_en), .pipe_in(s1), .pipe_out(s2));
  fp_div_stage #(.K(6)) u_stage3 (.clock(clock), .reset(reset), .clk_en(clk_en), .pipe_in(s2), .pipe_out(s3));
  fp_div_stage #(.K(6)) u_stage4 (.clock(clock), .reset(reset), .clk_en(clk_en), .pipe_in(s3), .pipe_out(s4));

  // The divisor is not needed once the last quotient bit is produced.
  logic unused_div;
  assign unused_div = ^s4.div;

  // ---------------- S5: normalize, round, pack ----------------
  logic [FP_EXPI_W-1:0] exp_n, exp_r;
  logic [FP_SIG_W-1:0]  mant;
  logic [FP_SIG_W:0]    mant_r;
  logic [FP_FRAC_W-1:0] frac;
  logic                 guard, sticky, round_up, ovf, unf;
  logic [FP_W-1:0]      result_nxt;

  always_comb begin
    // A quotient below 1.0 is shifted up one place; the missing bit beyond
    // the guard is then covered by the sticky remainder test.
    if (s4.q[FP_Q_W-1]) begin
      mant   = s4.q[FP_Q_W-1:2];
      guard  = s4.q[1];
      sticky = s4.q[0] | (s4.rem != '0);
      exp_n  = s4.exp;
    end else begin
      mant   = s4.q[FP_Q_W-2:1];
      guard  = s4.q[0];
      sticky = (s4.rem != '0);
      exp_n  = s4.exp - 10'd1;
    end
    round_up = guard & (sticky | mant[0]);
    mant_r   = {1'b0, mant} + {{FP_SIG_W{1'b0}}, round_up};
    // Carry-out leaves 1.000..0 one binade up; its fraction is zero either way.
    frac     = mant_r[FP_SIG_W] ? mant_r[FP_SIG_W-1:1] : mant_r[FP_FRAC_W-1:0];
    exp_r    = mant_r[FP_SIG_W] ? exp_n + 10'd1 : exp_n;
    ovf      = ($signed(exp_r) >= 10'sd255);
    unf      = ($signed(exp_r) <= 10'sd0);

    case (s4.spc)
      SPC_NAN:          result_nxt = FP_QNAN;
      SPC_INF, SPC_DBZ: result_nxt = FP_POS_INF | {s4.sign, 31'b0};
      SPC_ZERO:         result_nxt = {s4.sign, 31'b0};
      default: begin
        if (ovf) begin
          result_nxt = FP_POS_INF | {s4.sign, 31'b0};
        end else if (unf) begin
          result_nxt = {s4.sign, 31'b0};
        end else begin
          result_nxt = {s4.sign, exp_r[FP_EXP_W-1:0], frac};
        end
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      result <= '0;
    end else if (clk_en) begin
      result <= result_nxt;
    end
  end

`ifdef FP_DIV_FLAGS_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      nan              <= 1'b0;
      division_by_zero <= 1'b0;
      overflow         <= 1'b0;
      underflow        <= 1'b0;
      zero             <= 1'b0;
    end else if (clk_en) begin
      nan              <= (s4.spc == SPC_NAN);
      division_by_zero <= (s4.spc == SPC_DBZ);
      overflow         <= (s4.spc == SPC_NONE) && ovf;
      underflow        <= (s4.spc == SPC_NONE) && !ovf && unf;
      zero             <= (result_nxt[FP_W-2:0] == '0);
    end
  end
`endif

endmodule

// File: tb/tb_fp_div.sv
// Scoreboard bench for fp_div: the driver pushes the expected quotient for
// every accepted operand pair; a monitor pops and compares on the enabled edge
// on which that pair is due, and checks hold/reset/bubble values otherwise.
module tb_fp_div;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        clk_en = 1'b0;
  logic [31:0] dataa = '0;
  logic [31:0] datab = '0;
  logic [31:0] result;

  int n_checks = 0;
  int n_fail   = 0;
  int en_edges = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          due;
  } sb_entry_t;

  sb_entry_t sb[$];

  fp_div #(.LATENCY(6)) dut (
    .clock (clock),
    .reset (reset),
    .clk_en(clk_en),
    .dataa (dataa),
    .datab (datab),
    .result(result)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: result=%08h required=%08h at %0t", name, act, req, $time);
    end
  endtask

  // Quotient from the rules: exact integer division with 25 fraction bits,
  // keep 24 significant bits, round to nearest even on the dropped part plus
  // the remainder, then range-check the biased exponent.
  function automatic logic [31:0] ref_div(input logic [31:0] a, input logic [31:0] b);
    logic        s, up;
    int          ea, eb, e, sh;
    logic [63:0] ma, mb, num, qt, r, keep, dropped, half;
    logic        a_zero, a_inf, a_nan, b_zero, b_inf, b_nan;
    s      = a[31] ^ b[31];
    ea     = int'({24'd0, a[30:23]});
    eb     = int'({24'd0, b[30:23]});
    a_zero = (ea == 0);
    b_zero = (eb == 0);
    a_inf  = (ea == 255) && (a[22:0] == 0);
    b_inf  = (eb == 255) && (b[22:0] == 0);
    a_nan  = (ea == 255) && (a[22:0] != 0);
    b_nan  = (eb == 255) && (b[22:0] != 0);
    if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) return 32'h7FC00000;
    if (a_inf)  return {s, 8'hFF, 23'h0};
    if (b_zero) return {s, 8'hFF, 23'h0};
    if (b_inf)  return {s, 31'h0};
    if (a_zero) return {s, 31'h0};
    ma   = {40'd0, 1'b1, a[22:0]};
    mb   = {40'd0, 1'b1, b[22:0]};
    num  = ma << 25;
    qt   = num / mb;
    r    = num % mb;
    e    = ea - eb + 127;
    sh   = (qt >= (64'h1 << 25)) ? 2 : 1;
    if (sh == 1) e = e - 1;
    keep    = qt >> sh;
    dropped = qt & ((64'h1 << sh) - 64'h1);
    half    = 64'h1 << (sh - 1);
    up      = (dropped > half) || ((dropped == half) && ((r != 0) || keep[0]));
    keep    = keep + 64'(up);
    if (keep == (64'h1 << 24)) begin
      keep = keep >> 1;
      e    = e + 1;
    end
    if (e >= 255) return {s, 8'hFF, 23'h0};
    if (e <= 0)   return {s, 31'h0};
    return {s, e[7:0], keep[22:0]};
  endfunction

  function automatic logic [31:0] rand_op();
    logic [31:0] x;
    int          kind;
    x    = $urandom;
    kind = $urandom_range(0, 11);
    case (kind)
      0: x[30:0] = 31'h0;                               // signed zero
      1: x[30:0] = 31'h7F800000;                        // infinity
      2: begin x[30:23] = 8'hFF; x[22] = 1'b1; end      // NaN
      3: x[30:23] = 8'h00;                              // denormal
      4: x[30:23] = 8'(124 + $urandom_range(0, 6));     // near 1.0
      default: x[30:23] = 8'($urandom_range(1, 254));
    endcase
    return x;
  endfunction

  // Drive one clock's worth of inputs; pairs that the DUT will accept are
  // scored. With use_req the required value is taken as given.
  task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic en,
                       input logic rst, input logic use_req, input logic [31:0] req);
    sb_entry_t e;
    @(negedge clock);
    dataa  = a;
    datab  = b;
    clk_en = en;
    reset  = rst;
    if (en && !rst) begin
      e.a   = a;
      e.b   = b;
      e.exp = use_req ? req : ref_div(a, b);
      e.due = en_edges + 6;
      sb.push_back(e);
    end
  endtask

  task automatic drive_rand(input logic en);
    drive(rand_op(), rand_op(), en, 1'b0, 1'b0, 32'h0);
  endtask

  // Monitor
  initial begin
    logic [31:0] last_val;
    logic        s_en, s_rst;
    sb_entry_t   e;
    last_val = 32'h0;
    forever begin
      @(posedge clock);
      s_en  = clk_en;
      s_rst = reset;
      #1;
      if (s_rst) begin
        sb.delete();
        check("reset", result, 32'h0);
        last_val = 32'h0;
      end else if (s_en) begin
        en_edges++;
        if (sb.size() != 0 && sb[0].due < en_edges) begin
          e = sb.pop_front();
          n_checks++;
          n_fail++;
          $display("FAIL missed: a=%08h b=%08h due edge %0d not observed", e.a, e.b, e.due);
        end
        if (sb.size() != 0 && sb[0].due == en_edges) begin
          e = sb.pop_front();
          if (result !== e.exp)
            $display("  operands a=%08h b=%08h", e.a, e.b);
          check("quotient", result, e.exp);
          last_val = e.exp;
        end else begin
          check("bubble", result, 32'h0);
          last_val = 32'h0;
        end
      end else begin
        check("hold", result, last_val);
      end
    end
  end

  // Stimulus
  initial begin
    drive(0, 0, 1'b1, 1'b1, 1'b0, 0);
    drive(0, 0, 1'b0, 1'b1, 1'b0, 0);

    // Directed values, back to back
    drive(32'h40C00000, 32'h40000000, 1'b1, 1'b0, 1'b1, 32'h40400000); // 6/2
    drive(32'h3F800000, 32'h40400000, 1'b1, 1'b0, 1'b1, 32'h3EAAAAAB); // 1/3
    drive(32'h3F800000, 32'h00000000, 1'b1, 1'b0, 1'b1, 32'h7F800000); // 1/0
    drive(32'h00000000, 32'h00000000, 1'b1, 1'b0, 1'b1, 32'h7FC00000); // 0/0
    drive(32'hBF800000, 32'h7F800000, 1'b1, 1'b0, 1'b1, 32'h80000000); // -1/inf
    drive(32'h7F7FFFFF, 32'h3E800000, 1'b1, 1'b0, 1'b1, 32'h7F800000); // overflow
    drive(32'h00800000, 32'h41000000, 1'b1, 1'b0, 1'b1, 32'h00000000); // underflow
    drive(32'hC0C00000, 32'h40000000, 1'b1, 1'b0, 1'b1, 32'hC0400000); // -6/2
    drive(32'h3F800000, 32'h80000000, 1'b1, 1'b0, 1'b1, 32'hFF800000); // 1/-0
    drive(32'hFF800000, 32'h40000000, 1'b1, 1'b0, 1'b1, 32'hFF800000); // -inf/2
    drive(32'h7F800000, 32'hFF800000, 1'b1, 1'b0, 1'b1, 32'h7FC00000); // inf/inf
    drive(32'hFFC00001, 32'h3F800000, 1'b1, 1'b0, 1'b1, 32'h7FC00000); // NaN/1
    drive(32'h80000000, 32'h40A00000, 1'b1, 1'b0, 1'b1, 32'h80000000); // -0/5
    drive(32'h00000001, 32'h3F800000, 1'b1, 1'b0, 1'b1, 32'h00000000); // denormal/1
    drive(32'h40000000, 32'h7F800000, 1'b1, 1'b0, 1'b1, 32'h00000000); // 2/inf

    // Stream of 8 pairs with two clk_en gaps
    for (int i = 0; i < 8; i++) begin
      drive_rand(1'b1);
      if (i == 2 || i == 5) begin
        drive_rand(1'b0);
        drive_rand(1'b0);
      end
    end

    // Random traffic with random enable
    for (int i = 0; i < 300; i++) begin
      drive_rand($urandom_range(0, 4) != 0);
    end

    // Reset on the 3rd enabled cycle of an operation, then refill
    drive(32'h40C00000, 32'h40000000, 1'b1, 1'b0, 1'b1, 32'h40400000);
    drive_rand(1'b1);
    drive(32'h3F800000, 32'h40400000, 1'b1, 1'b1, 1'b0, 32'h0);
    for (int i = 0; i < 12; i++) begin
      drive_rand(1'b1);
    end

    // Drain with 0/1, then one idle cycle so the monitor sees the last edge
    for (int i = 0; i < 7; i++) begin
      drive(32'h00000000, 32'h3F800000, 1'b1, 1'b0, 1'b1, 32'h00000000);
    end
    drive(32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    @(negedge clock);

    // Exactly the pairs from the last five enabled edges are still in flight.
    n_checks++;
    if (sb.size() != 5) begin
      n_fail++;
      $display("FAIL drain: in-flight entries=%0d required=5", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
